// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: configurable-frame UART transmitter fed by a valid/ready FIFO
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_W-1:0]     clk_per_bit,
  input  logic [1:0]           parity_mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 tx,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     fifo_count,
  output logic [2:0]           state_out
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int IDX_W = $clog2(DATA_BITS);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [DATA_BITS-1:0] shreg, head;
  logic [DIV_W-1:0] div, clk_cnt;
  logic [IDX_W-1:0] bit_idx;
  logic par_en, par_bit, push, pop, bit_end, last_stop;
  assign in_ready  = fifo_count < CNT_W'(FIFO_DEPTH);
  assign push      = in_valid && in_ready;
  assign bit_end   = clk_cnt == div - DIV_W'(1);
  assign last_stop = state == STOP && bit_end && bit_idx == IDX_W'(STOP_BITS - 1);
  assign head      = mem[rd_ptr];
  assign pop       = fifo_count != '0 && (state == IDLE || last_stop);
  assign state_out = state;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      wr_ptr     <= wr_ptr + PTR_W'(push);
      rd_ptr     <= rd_ptr + PTR_W'(pop);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
    end
  end
  // bit_idx counts data bits in DATA and stop bits in STOP; the data word shifts out of shreg
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      div     <= DIV_W'(1);
      par_en  <= 1'b0;
      par_bit <= 1'b0;
    end else begin
      done    <= 1'b0;
      clk_cnt <= bit_end ? '0 : clk_cnt + DIV_W'(1);
      case (state)
        IDLE: begin
          tx      <= 1'b1;
          busy    <= 1'b0;
          clk_cnt <= '0;
        end
        START: if (bit_end) begin
          state   <= DATA;
          bit_idx <= '0;
          tx      <= shreg[0];
        end
        DATA: if (bit_end) begin
          shreg   <= shreg >> 1;
          bit_idx <= bit_idx + IDX_W'(1);
          tx      <= shreg[1];
          if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
            state   <= par_en ? PARITY : STOP;
            tx      <= par_en ? par_bit : 1'b1;
            bit_idx <= '0;
          end
        end
        PARITY: if (bit_end) begin
          state <= STOP;
          tx    <= 1'b1;
        end
        STOP: if (bit_end) begin
          bit_idx <= bit_idx + IDX_W'(1);
          if (last_stop) begin
            done    <= 1'b1;
            state   <= IDLE;
            busy    <= 1'b0;
            bit_idx <= '0;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
      // a pop overrides the IDLE/STOP outcome so the next start bit follows with no gap
      if (pop) begin
        state   <= START;
        tx      <= 1'b0;
        busy    <= 1'b1;
        clk_cnt <= '0;
        shreg   <= head;
        div     <= clk_per_bit == '0 ? DIV_W'(1) : clk_per_bit;
        par_en  <= ^parity_mode;
        par_bit <= parity_mode[1] ^ (^head);
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of uart_tx_fifo in three parameter sets
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, in_valid;
  logic [15:0] cpb;
  logic [1:0] pm, sel;
  logic [8:0] din;
  logic v_a, v_b, v_c;
  logic rdy_a, rdy_b, rdy_c, tx_a, tx_b, tx_c, busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic [2:0] cnt_a, cnt_b, cnt_c, st_a, st_b, st_c;
  logic rdy_s, tx_s, busy_s, done_s;
  logic [2:0] cnt_s, st_s;
  int n_cmp = 0, n_bad = 0;
  assign v_a = in_valid && sel == 2'd0;
  assign v_b = in_valid && sel == 2'd1;
  assign v_c = in_valid && sel == 2'd2;
  assign rdy_s  = sel == 2'd0 ? rdy_a  : sel == 2'd1 ? rdy_b  : rdy_c;
  assign tx_s   = sel == 2'd0 ? tx_a   : sel == 2'd1 ? tx_b   : tx_c;
  assign busy_s = sel == 2'd0 ? busy_a : sel == 2'd1 ? busy_b : busy_c;
  assign done_s = sel == 2'd0 ? done_a : sel == 2'd1 ? done_b : done_c;
  assign cnt_s  = sel == 2'd0 ? cnt_a  : sel == 2'd1 ? cnt_b  : cnt_c;
  assign st_s   = sel == 2'd0 ? st_a   : sel == 2'd1 ? st_b   : st_c;
  uart_tx_fifo u_a (
    .clk(clk), .rst(rst), .clk_per_bit(cpb), .parity_mode(pm), .in_valid(v_a),
    .in_ready(rdy_a), .in_data(din[7:0]), .tx(tx_a), .busy(busy_a), .done(done_a),
    .fifo_count(cnt_a), .state_out(st_a));
  uart_tx_fifo #(.DATA_BITS(7)) u_b (
    .clk(clk), .rst(rst), .clk_per_bit(cpb), .parity_mode(pm), .in_valid(v_b),
    .in_ready(rdy_b), .in_data(din[6:0]), .tx(tx_b), .busy(busy_b), .done(done_b),
    .fifo_count(cnt_b), .state_out(st_b));
  uart_tx_fifo #(.STOP_BITS(2)) u_c (
    .clk(clk), .rst(rst), .clk_per_bit(cpb), .parity_mode(pm), .in_valid(v_c),
    .in_ready(rdy_c), .in_data(din[7:0]), .tx(tx_c), .busy(busy_c), .done(done_c),
    .fifo_count(cnt_c), .state_out(st_c));
  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      n_cmp++; if ({tx_s, busy_s, done_s, rdy_s} !== 4'b1001) begin n_bad++; $display("FAIL reset_outs dut=%0d got %b want 1001", s, {tx_s, busy_s, done_s, rdy_s}); end
      n_cmp++; if (cnt_s !== 3'd0) begin n_bad++; $display("FAIL reset_count dut=%0d got %0d want 0", s, cnt_s); end
      n_cmp++; if (st_s !== 3'd0) begin n_bad++; $display("FAIL reset_state dut=%0d got %0d want 0", s, st_s); end
    end
    rst = 1'b0;
  endtask
  task automatic test_basic;
    logic [9:0] fb;
    fb = 10'b1101001010;
    sel = 2'd0; cpb = 16'd4; pm = 2'd0;
    @(negedge clk); in_valid = 1'b1; din = 9'h0A5;
    @(negedge clk); in_valid = 1'b0;
    n_cmp++; if (cnt_s !== 3'd1) begin n_bad++; $display("FAIL basic_count got %0d want 1", cnt_s); end
    n_cmp++; if (tx_s !== 1'b1) begin n_bad++; $display("FAIL basic_latency got %b want 1", tx_s); end
    for (int k = 0; k < 42; k++) begin
      @(negedge clk);
      n_cmp++; if (tx_s !== (k < 40 ? fb[k/4] : 1'b1)) begin n_bad++; $display("FAIL basic_tx k=%0d got %b", k, tx_s); end
      n_cmp++; if (done_s !== (k == 40)) begin n_bad++; $display("FAIL basic_done k=%0d got %b", k, done_s); end
      n_cmp++; if (busy_s !== (k < 40)) begin n_bad++; $display("FAIL basic_busy k=%0d got %b", k, busy_s); end
    end
  endtask
  task automatic test_parity;
    logic [9:0] fb;
    for (int m = 1; m <= 2; m++) begin
      sel = 2'd1; cpb = 16'd4; pm = 2'(m);
      fb = m == 1 ? 10'b1010101010 : 10'b1110101010;
      @(negedge clk); in_valid = 1'b1; din = 9'h055;
      @(negedge clk); in_valid = 1'b0;
      for (int k = 0; k < 42; k++) begin
        @(negedge clk);
        n_cmp++; if (tx_s !== (k < 40 ? fb[k/4] : 1'b1)) begin n_bad++; $display("FAIL parity%0d_tx k=%0d got %b", m, k, tx_s); end
        n_cmp++; if (done_s !== (k == 40)) begin n_bad++; $display("FAIL parity%0d_done k=%0d got %b", m, k, done_s); end
      end
    end
    pm = 2'd0;
  endtask
  task automatic test_back_to_back;
    logic [9:0] fr [3];
    logic exp_tx;
    logic [2:0] exp_cnt;
    int k;
    fr[0] = 10'b1000000010; fr[1] = 10'b1100000000; fr[2] = 10'b1111111110;
    sel = 2'd0; cpb = 16'd2; pm = 2'd0;
    for (int c = 0; c < 65; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        k = c - 2;
        exp_tx = k < 60 ? fr[k/20][(k%20)/2] : 1'b1;
        exp_cnt = k == 0 ? 3'd1 : k < 20 ? 3'd2 : k < 40 ? 3'd1 : 3'd0;
        n_cmp++; if (tx_s !== exp_tx) begin n_bad++; $display("FAIL b2b_tx k=%0d got %b want %b", k, tx_s, exp_tx); end
        n_cmp++; if (done_s !== (k == 20 || k == 40 || k == 60)) begin n_bad++; $display("FAIL b2b_done k=%0d got %b", k, done_s); end
        n_cmp++; if (busy_s !== (k < 60)) begin n_bad++; $display("FAIL b2b_busy k=%0d got %b", k, busy_s); end
        n_cmp++; if (cnt_s !== exp_cnt) begin n_bad++; $display("FAIL b2b_count k=%0d got %0d want %0d", k, cnt_s, exp_cnt); end
      end
      in_valid = c < 3;
      din = c == 0 ? 9'h001 : c == 1 ? 9'h080 : 9'h0FF;
    end
  endtask
  task automatic test_full;
    logic [8:0] w [6];
    logic [7:0] got;
    logic acc;
    int i, off, j;
    w[0] = 9'h011; w[1] = 9'h021; w[2] = 9'h022; w[3] = 9'h023; w[4] = 9'h024; w[5] = 9'h025;
    sel = 2'd0; cpb = 16'd4; pm = 2'd0;
    i = 0; acc = 1'b0; got = '0;
    for (int c = 0; c < 246; c++) begin
      @(negedge clk);
      if (in_valid && acc) i++;
      if (c >= 5 && c <= 41) begin
        n_cmp++; if (rdy_s !== 1'b0) begin n_bad++; $display("FAIL full_ready c=%0d got %b want 0", c, rdy_s); end
        n_cmp++; if (cnt_s !== 3'd4) begin n_bad++; $display("FAIL full_count c=%0d got %0d want 4", c, cnt_s); end
      end
      if (c == 42) begin
        n_cmp++; if (cnt_s !== 3'd3) begin n_bad++; $display("FAIL full_pop_count got %0d want 3", cnt_s); end
        n_cmp++; if (rdy_s !== 1'b1) begin n_bad++; $display("FAIL full_reopen got %b want 1", rdy_s); end
      end
      if (c == 43) begin
        n_cmp++; if (cnt_s !== 3'd4) begin n_bad++; $display("FAIL full_refill got %0d want 4", cnt_s); end
      end
      if (c >= 42 && c < 242) begin
        off = (c - 42) % 40;
        j = (c - 42) / 40;
        if (off >= 6 && off <= 34 && off % 4 == 2) got[(off-6)/4] = tx_s;
        if (off == 0) begin
          n_cmp++; if (done_s !== 1'b1) begin n_bad++; $display("FAIL full_done frame=%0d got %b want 1", j, done_s); end
        end
        if (off == 38) begin
          n_cmp++; if (tx_s !== 1'b1) begin n_bad++; $display("FAIL full_stop frame=%0d got %b want 1", j, tx_s); end
          n_cmp++; if (got !== w[j+1][7:0]) begin n_bad++; $display("FAIL full_word frame=%0d got %h want %h", j, got, w[j+1][7:0]); end
        end
      end
      in_valid = i < 6;
      din = i < 6 ? w[i] : 9'h000;
      acc = rdy_s;
    end
  endtask
  task automatic test_reset_mid;
    sel = 2'd0; cpb = 16'd4; pm = 2'd0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      rst = 1'b0;
      if (c == 12) begin
        n_cmp++; if (st_s !== 3'd2) begin n_bad++; $display("FAIL rmid_in_data got %0d want 2", st_s); end
        n_cmp++; if (cnt_s !== 3'd1) begin n_bad++; $display("FAIL rmid_queued got %0d want 1", cnt_s); end
        rst = 1'b1;
      end
      if (c == 13) begin
        n_cmp++; if (cnt_s !== 3'd0) begin n_bad++; $display("FAIL rmid_count got %0d want 0", cnt_s); end
        n_cmp++; if (busy_s !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got %b want 0", busy_s); end
        n_cmp++; if (st_s !== 3'd0) begin n_bad++; $display("FAIL rmid_state got %0d want 0", st_s); end
      end
      if (c >= 13) begin
        n_cmp++; if (tx_s !== 1'b1) begin n_bad++; $display("FAIL rmid_tx c=%0d got %b want 1", c, tx_s); end
        n_cmp++; if (done_s !== 1'b0) begin n_bad++; $display("FAIL rmid_done c=%0d got %b want 0", c, done_s); end
      end
      in_valid = c < 2;
      din = c == 0 ? 9'h03C : 9'h00F;
    end
    rst = 1'b0;
  endtask
  task automatic test_fast;
    logic [10:0] fb;
    int k;
    fb = 11'b11101001010;
    sel = 2'd2; cpb = 16'd0; pm = 2'd0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        k = c - 2;
        n_cmp++; if (tx_s !== (k < 11 ? fb[k] : 1'b1)) begin n_bad++; $display("FAIL fast_tx k=%0d got %b", k, tx_s); end
        n_cmp++; if (done_s !== (k == 11)) begin n_bad++; $display("FAIL fast_done k=%0d got %b", k, done_s); end
        n_cmp++; if (busy_s !== (k < 11)) begin n_bad++; $display("FAIL fast_busy k=%0d got %b", k, busy_s); end
      end
      if (c == 2) cpb = 16'd7;
      in_valid = c == 0;
      din = 9'h0A5;
    end
    cpb = 16'd4;
  endtask
  initial begin
    rst = 1'b1; in_valid = 1'b0; cpb = 16'd4; pm = 2'd0; sel = 2'd0; din = '0;
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_full();
    test_reset_mid();
    test_fast();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
